seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receive-side monitor for the 8-digit multiplexed seven-segment bus (cc, an, odp) driven by the counter/display top.
- Samples the scanned bus and waits for each digit slot to settle.
- Decodes each segment pattern back to a 4-bit nibble and assembles a full 32-bit display word per complete scan.
- Used for self-checking benches and for on-board readback of the displayed value.

Parameters:
- NUM_DIGITS, 8, anodes on the bus; value width is 4*NUM_DIGITS.
- STABLE_CYCLES, 4, consecutive identical samples required before a slot is captured; must be >= 2.
- TIMEOUT, 65536, cycles without any capture before a partial frame is discarded.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset; rst=0 resets.
- cc  in  7  active-low segment cathodes; cc[6]=g ... cc[0]=a.
- an  in  NUM_DIGITS  active-low anode enables; an[i]=0 selects digit i.
- odp  in  1  active-low decimal point.
- value  out  4*NUM_DIGITS  last complete frame; digit i occupies value[4i+3:4i].
- dp_mask  out  NUM_DIGITS  bit i=1 when the DP of digit i was lit in the last frame.
- blank_mask  out  NUM_DIGITS  bit i=1 when digit i was blank (cc=7'h7F) in the last frame.
- frame_valid  out  1  one-cycle pulse when value, dp_mask and blank_mask update.
- err_pattern  out  1  one-cycle pulse when an undecodable cc is captured.
- err_anode  out  1  one-cycle pulse when a stable sample has more than one an bit low.
- err_count  out  8  saturating count of err_pattern plus err_anode events.
- stale  out  1  one-cycle pulse when TIMEOUT discards a partial frame.

Behaviour:
- Reset: all outputs are 0. Internal sample, shadow, seen, stability counter and timeout counter are cleared. Reset takes effect immediately, including in the middle of a frame.
- Stage 1: {an, cc, odp} is registered every cycle; all logic below works on this registered sample.
- Stability counter:
  - Clears to 0 whenever the sample differs from the previous sample.
  - Otherwise increments, saturating at STABLE_CYCLES-1.
  - A "captured" flag allows exactly one capture per stable interval and clears on any sample change.
- Capture condition: counter reaches STABLE_CYCLES-1, captured=0, and exactly one an bit is low (index i).
- On capture:
  - shadow_val[i] <= decoded nibble; shadow_dp[i] <= ~odp; seen[i] <= 1; timeout counter clears.
  - Decode table (hex cc -> nibble): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->b, 46->C, 21->d, 06->E, 0E->F.
  - cc=7F (blank): nibble 0, shadow_blank[i] <= 1, counted as seen.
  - Any other cc: nibble 0, err_pattern pulses, err_count increments, slot still counted as seen.
  - A recapture of an already-seen slot overwrites that slot.
- All an bits high when the stable point is reached: no capture, no error.
- Two or more an bits low when the stable point is reached: err_anode pulses, err_count increments, no capture.
- Frame publish:
  - The cycle after seen becomes all ones, value/dp_mask/blank_mask load from the shadow registers and frame_valid pulses.
  - In that same cycle, seen and the shadow_blank registers clear.
  - No capture can coincide with publish, since STABLE_CYCLES >= 2.
- Latency: frame_valid is asserted STABLE_CYCLES+2 cycles after the bus changes to the last missing digit.
- Timeout: counts cycles while seen != 0. Reaching TIMEOUT-1 clears seen, pulses stale, and leaves value unchanged.
- err_count: saturates at 255 and clears only on reset.

Test Plan:
- Reset: hold rst=0 with random bus, release -> all outputs 0 and no pulses for 20 cycles.
- Full frame: scan digits 0..7 with cc patterns for 1,2,3,4,5,6,7,8, each held 6 cycles, odp lit only on digit 3 -> exactly one frame_valid, value=32'h87654321, dp_mask=8'h08, blank_mask=0.
- Glitch rejection: hold each slot 3 cycles (< STABLE_CYCLES) -> no capture and no frame_valid. Then hold 4 cycles -> capture succeeds.
- Errors: cc=7'h55 on digit 2 -> err_pattern pulse and err_count=1. an=8'hFC -> err_anode pulse and err_count=2. Completed frame still publishes with value digit 2 = 0.
- Blank and hex: digits 0..5 show A,b,C,d,E,F, and digits 6..7 show cc=7F -> value=32'h00FEDCBA, blank_mask=8'hC0.
- Timeout and mid-frame reset: capture 3 digits then idle TIMEOUT cycles -> stale pulse, value unchanged. Assert rst mid-frame -> outputs 0 at once, and the next complete scan publishes correctly.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed seven-segment bus as seen on the board pins, all lines active-low.
// The bus has no handshake: the driver holds a digit slot for a while and the receiver waits for it to settle.
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 8
);
  logic [6:0]            cc;
  logic [NUM_DIGITS-1:0] an;
  logic                  odp;

  modport master (output cc, an, odp);
  modport slave  (input  cc, an, odp);
endinterface

// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a scanned seven-segment bus: waits for each digit slot to settle,
// decodes its segments back to a nibble and publishes one display word per complete scan.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  seg7_scan_decoder_if.slave      bus,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    frame_valid,
  output logic                    err_pattern,
  output logic                    err_anode,
  output logic [7:0]              err_count,
  output logic                    stale
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  logic [NUM_DIGITS-1:0] samp_an;
  logic [6:0]            samp_cc;
  logic                  samp_odp;
  logic [CW-1:0]         stab_cnt;
  logic                  captured;

  logic [W-1:0]          shadow_val;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [NUM_DIGITS-1:0] shadow_blank;
  logic [NUM_DIGITS-1:0] seen;
  logic [TW-1:0]         tcnt;

  // Bit 4 flags a legal glyph, bits 3:0 carry the nibble.
  function automatic logic [4:0] decode(input logic [6:0] c);
    logic [4:0] r;
    case (c)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic                  changed;
  logic                  stable_pt;
  logic [NUM_DIGITS-1:0] an_low;
  logic                  any_low;
  logic                  one_low;
  logic                  do_capture;
  logic                  do_err_anode;
  logic                  is_blank;
  logic [4:0]            dec;
  logic                  pattern_ok;
  logic [3:0]            cap_nib;
  logic [IW-1:0]         cap_idx;
  logic                  publish;

  // The stability counter compares the incoming bus with the registered sample,
  // so it restarts on the same edge that registers a new value.
  assign changed    = ({bus.an, bus.cc, bus.odp} != {samp_an, samp_cc, samp_odp});
  assign stable_pt  = (stab_cnt == CNT_LAST) && !captured;

  assign an_low       = ~samp_an;
  assign any_low      = |an_low;
  assign one_low      = any_low && ((an_low & (an_low - 1'b1)) == '0);
  assign do_capture   = stable_pt && one_low;
  assign do_err_anode = stable_pt && any_low && !one_low;

  assign is_blank   = (samp_cc == 7'h7F);
  assign dec        = decode(samp_cc);
  assign pattern_ok = dec[4] || is_blank;
  assign cap_nib    = dec[4] ? dec[3:0] : 4'h0;
  assign publish    = &seen;

  always_comb begin
    cap_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_low[i]) cap_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_an  <= '0;
      samp_cc  <= '0;
      samp_odp <= 1'b0;
      stab_cnt <= '0;
      captured <= 1'b0;
    end else begin
      samp_an  <= bus.an;
      samp_cc  <= bus.cc;
      samp_odp <= bus.odp;
      if (changed) begin
        stab_cnt <= '0;
        captured <= 1'b0;
      end else begin
        if (stab_cnt != CNT_LAST) stab_cnt <= stab_cnt + 1'b1;
        if (stable_pt) captured <= 1'b1;
      end
    end
  end

  // Publish and capture never overlap: a capture needs at least one settling cycle after
  // the previous one, which is exactly the cycle publish occupies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_val   <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      seen         <= '0;
      tcnt         <= '0;
      value        <= '0;
      dp_mask      <= '0;
      blank_mask   <= '0;
      frame_valid  <= 1'b0;
      err_pattern  <= 1'b0;
      stale        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err_pattern <= 1'b0;
      stale       <= 1'b0;
      if (publish) begin
        value        <= shadow_val;
        dp_mask      <= shadow_dp;
        blank_mask   <= shadow_blank;
        frame_valid  <= 1'b1;
        seen         <= '0;
        shadow_blank <= '0;
        tcnt         <= '0;
      end else if (do_capture) begin
        shadow_val[{cap_idx, 2'b00} +: 4] <= cap_nib;
        shadow_dp[cap_idx]    <= ~samp_odp;
        shadow_blank[cap_idx] <= is_blank;
        seen[cap_idx]         <= 1'b1;
        tcnt                  <= '0;
        err_pattern           <= !pattern_ok;
      end else if (seen == '0) begin
        tcnt <= '0;
      end else if (tcnt == T_LAST) begin
        seen  <= '0;
        stale <= 1'b1;
        tcnt  <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_anode <= 1'b0;
      err_count <= '0;
    end else begin
      err_anode <= do_err_anode;
      if (((do_capture && !pattern_ok) || do_err_anode) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scans from the test plan plus random scans
// checked against a slot-level model of what a complete display frame should contain.
module tb_seg7_scan_decoder;
  localparam int N = 8;
  localparam int S = 4;
  localparam int T = 300;
  localparam int FW = 6 * N;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.NUM_DIGITS(N)) bus ();

  logic [4*N-1:0] value;
  logic [N-1:0]   dp_mask;
  logic [N-1:0]   blank_mask;
  logic           frame_valid;
  logic           err_pattern;
  logic           err_anode;
  logic [7:0]     err_count;
  logic           stale;

  seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .value(value), .dp_mask(dp_mask), .blank_mask(blank_mask),
    .frame_valid(frame_valid), .err_pattern(err_pattern), .err_anode(err_anode),
    .err_count(err_count), .stale(stale)
  );

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records every published frame {blank, dp, value} and counts pulses.
  logic [FW-1:0] got_q[$];
  int            got_cyc_q[$];
  int n_frame = 0, n_errp = 0, n_erra = 0, n_stale = 0;

  always @(negedge clk) begin
    if (frame_valid) begin
      got_q.push_back({blank_mask, dp_mask, value});
      got_cyc_q.push_back(cyc);
      n_frame <= n_frame + 1;
    end
    if (err_pattern) n_errp  <= n_errp + 1;
    if (err_anode)   n_erra  <= n_erra + 1;
    if (stale)       n_stale <= n_stale + 1;
  end

  // Reference model: per-slot contents and which slots have been captured this frame.
  logic [FW-1:0] exp_q[$];
  int m_nib [N];
  bit m_dp [N];
  bit m_blank [N];
  bit m_seen [N];

  function automatic logic [FW-1:0] model_frame();
    logic [4*N-1:0] v;
    logic [N-1:0]   d;
    logic [N-1:0]   b;
    for (int i = 0; i < N; i++) begin
      v[4*i +: 4] = 4'(m_nib[i]);
      d[i] = m_dp[i];
      b[i] = m_blank[i];
    end
    return {b, d, v};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_seen[i]  = 0;
      m_blank[i] = 0;
    end
  endtask

  task automatic model_capture(input int d, input int nib, input bit dp, input bit blank);
    bit all;
    m_nib[d]   = nib;
    m_dp[d]    = dp;
    m_blank[d] = blank;
    m_seen[d]  = 1;
    all = 1;
    for (int i = 0; i < N; i++) if (!m_seen[i]) all = 0;
    if (all) begin
      exp_q.push_back(model_frame());
      model_clear();
    end
  endtask

  task automatic drive(input logic [N-1:0] an, input logic [6:0] cc, input logic odp, input int hold);
    bus.an  = an;
    bus.cc  = cc;
    bus.odp = odp;
    repeat (hold) @(negedge clk);
  endtask

  function automatic logic [N-1:0] sel(input int d);
    logic [N-1:0] a;
    a = '1;
    a[d] = 1'b0;
    return a;
  endfunction

  task automatic idle(input int n);
    drive('1, 7'h7F, 1'b1, n);
  endtask

  task automatic show_digit(input int d, input int nib, input bit dp, input int hold);
    drive(sel(d), seg_tab[nib], ~dp, hold);
    if (hold >= S) model_capture(d, nib, dp, 0);
  endtask

  task automatic show_blank(input int d, input int hold);
    drive(sel(d), 7'h7F, 1'b1, hold);
    if (hold >= S) model_capture(d, 0, 0, 1);
  endtask

  task automatic wait_frame(output bit ok, output logic [FW-1:0] f, output int fc);
    ok = 0;
    f  = '0;
    fc = 0;
    for (int k = 0; k < 40; k++) begin
      if (got_q.size() > 0) begin
        f  = got_q.pop_front();
        fc = got_cyc_q.pop_front();
        ok = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.an  = N'($urandom);
      bus.cc  = 7'($urandom);
      bus.odp = 1'($urandom);
      @(negedge clk);
      total++;
      if ({value, dp_mask, blank_mask, frame_valid, err_pattern, err_anode, err_count, stale} !== '0) begin
        bad++;
        $display("FAIL reset_hold outputs=%h required 0", {value, dp_mask, blank_mask, err_count});
      end
    end
    bus.an = '1; bus.cc = 7'h7F; bus.odp = 1'b1;
    rst = 1'b1;
    model_clear();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total++;
      if ({value, dp_mask, blank_mask, frame_valid, err_pattern, err_anode, err_count, stale} !== '0) begin
        bad++;
        $display("FAIL reset_release cycle=%0d outputs=%h required 0", k, {value, dp_mask, blank_mask, err_count});
      end
    end
  endtask

  task automatic test_full_frame();
    bit ok; logic [FW-1:0] f; int fc; int c; int nf;
    nf = n_frame;
    for (int d = 0; d < N - 1; d++) show_digit(d, d + 1, d == 3, 6);
    c = cyc;
    show_digit(N - 1, N, 0, 6);
    idle(10);
    wait_frame(ok, f, fc);
    total++;
    if (!ok || f !== exp_q.pop_front()) begin
      bad++; $display("FAIL full_frame_model got=%h ok=%0d", f, ok);
    end
    total++;
    if (f !== {8'h00, 8'h08, 32'h87654321}) begin
      bad++; $display("FAIL full_frame_value got=%h required %h", f, {8'h00, 8'h08, 32'h87654321});
    end
    total++;
    if (fc - c !== S + 2) begin
      bad++; $display("FAIL full_frame_latency got=%0d required %0d", fc - c, S + 2);
    end
    total++;
    if (n_frame - nf !== 1) begin
      bad++; $display("FAIL full_frame_count got=%0d required 1", n_frame - nf);
    end
  endtask

  task automatic test_glitch();
    bit ok; logic [FW-1:0] f; int fc; int nf;
    nf = n_frame;
    for (int d = 0; d < N; d++) show_digit(d, 15 - d, d[0], S - 1);
    for (int d = 0; d < N - 1; d++) show_digit(d, 15 - d, d[0], S);
    idle(12);
    total++;
    if (n_frame !== nf || got_q.size() != 0) begin
      bad++; $display("FAIL glitch_no_frame frames=%0d required %0d", n_frame, nf);
    end
    show_digit(N - 1, 15 - (N - 1), 1'b1, S);
    idle(10);
    wait_frame(ok, f, fc);
    total++;
    if (!ok || f !== exp_q.pop_front()) begin
      bad++; $display("FAIL glitch_frame got=%h ok=%0d", f, ok);
    end
  endtask

  task automatic test_errors();
    bit ok; logic [FW-1:0] f; int fc; int ep; int ea;
    ep = n_errp; ea = n_erra;
    show_digit(0, 9, 0, 6);
    show_digit(1, 8, 0, 6);
    drive(sel(2), 7'h55, 1'b1, 6);
    model_capture(2, 0, 0, 0);
    total++;
    if (n_errp - ep !== 1 || err_count !== 8'd1) begin
      bad++; $display("FAIL err_pattern pulses=%0d count=%0d required 1 and 1", n_errp - ep, err_count);
    end
    drive(8'hFC, seg_tab[5], 1'b1, 6);
    total++;
    if (n_erra - ea !== 1 || err_count !== 8'd2) begin
      bad++; $display("FAIL err_anode pulses=%0d count=%0d required 1 and 2", n_erra - ea, err_count);
    end
    for (int d = 3; d < N; d++) show_digit(d, 10 - d, 0, 6);
    idle(10);
    wait_frame(ok, f, fc);
    total++;
    if (!ok || f !== exp_q.pop_front() || f[31:0] !== 32'h34567089) begin
      bad++; $display("FAIL err_frame got=%h ok=%0d required value 34567089", f, ok);
    end
  endtask

  task automatic test_blank_hex();
    bit ok; logic [FW-1:0] f; int fc;
    for (int d = 0; d < 6; d++) show_digit(d, 10 + d, 0, 5);
    show_blank(6, 5);
    show_blank(7, 5);
    idle(10);
    wait_frame(ok, f, fc);
    total++;
    if (!ok || f !== exp_q.pop_front() || f !== {8'hC0, 8'h00, 32'h00FEDCBA}) begin
      bad++; $display("FAIL blank_hex got=%h ok=%0d required %h", f, ok, {8'hC0, 8'h00, 32'h00FEDCBA});
    end
  endtask

  task automatic test_timeout_reset();
    bit ok; logic [FW-1:0] f; int fc; int ns; int nf; logic [4*N-1:0] vr;
    vr = value; ns = n_stale; nf = n_frame;
    for (int d = 0; d < 3; d++) show_digit(d, d + 4, 0, 6);
    for (int k = 0; k < 2 * T && n_stale == ns; k++) @(negedge clk);
    model_clear();
    total++;
    if (n_stale - ns !== 1 || value !== vr || n_frame !== nf) begin
      bad++; $display("FAIL timeout stale=%0d value=%h required 1 and %h", n_stale - ns, value, vr);
    end
    for (int d = 3; d < N; d++) show_digit(d, d, 0, 6);
    idle(12);
    total++;
    if (n_frame !== nf || got_q.size() != 0) begin
      bad++; $display("FAIL timeout_discard frames=%0d required %0d", n_frame, nf);
    end
    for (int d = 0; d < 3; d++) show_digit(d, d + 1, 1, 6);
    rst = 1'b0;
    #1;
    total++;
    if ({value, dp_mask, blank_mask, frame_valid, err_pattern, err_anode, err_count, stale} !== '0) begin
      bad++; $display("FAIL midframe_reset outputs=%h required 0", {value, dp_mask, blank_mask, err_count});
    end
    idle(3);
    rst = 1'b1;
    model_clear();
    idle(2);
    for (int d = 0; d < N; d++) show_digit(d, $urandom_range(0, 15), 1'($urandom), 6);
    idle(10);
    wait_frame(ok, f, fc);
    total++;
    if (!ok || f !== exp_q.pop_front()) begin
      bad++; $display("FAIL post_reset_frame got=%h ok=%0d", f, ok);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [FW-1:0] f; int fc; int frames; int ec;
    frames = 0;
    ec = err_count;
    for (int it = 0; it < 2000 && frames < 6; it++) begin
      int d; int hold;
      d = $urandom_range(0, N - 1);
      hold = $urandom_range(2, 7);
      if ($urandom_range(0, 7) == 0) show_blank(d, hold);
      else show_digit(d, $urandom_range(0, 15), 1'($urandom), hold);
      idle($urandom_range(1, 2));
      if (exp_q.size() > 0) begin
        wait_frame(ok, f, fc);
        total++;
        if (!ok || f !== exp_q.pop_front()) begin
          bad++; $display("FAIL random_frame idx=%0d got=%h ok=%0d", frames, f, ok);
        end
        frames++;
      end
    end
    total++;
    if (frames !== 6 || err_count !== 8'(ec)) begin
      bad++; $display("FAIL random_summary frames=%0d err_count=%0d required 6 and %0d", frames, err_count, ec);
    end
  endtask

  initial begin
    bus.an = '1; bus.cc = 7'h7F; bus.odp = 1'b1;
    model_clear();
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_glitch();
    test_errors();
    test_blank_hex();
    test_timeout_reset();
    test_back_to_back();
    total++;
    if (got_q.size() != 0) begin
      bad++; $display("FAIL unexpected_frames got=%0d required 0", got_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cycles=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
